// File: rtl/toggle_pkg.sv
// Shared definitions for the push-button conditioning stage feeding the toggle flip-flop.
package toggle_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_STABLE_LO = 3'd1,
    ST_WAIT_HI   = 3'd2,
    ST_STABLE_HI = 3'd3,
    ST_WAIT_LO   = 3'd4
  } state_e;

  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam int DEBOUNCE_SIM     = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for any asynchronous level input; both stages reset to 0.
module sync2 (
  input  logic clk,
  input  logic restn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignment so both stages shift on the same edge.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/toggle_debounce.sv
// Synchronises and debounces a raw button, emitting one t_out pulse per qualified press.
module toggle_debounce
  import toggle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic restn,
  input  logic btn_in,
  input  logic en,
  output logic t_out,
  output logic btn_level,
  output logic busy
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_params
    $error("toggle_debounce: DEBOUNCE_CYCLES must lie in 2 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  logic             prev_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_out_q, t_out_d;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_inc;

  sync2 u_sync (
    .clk   (clk),
    .restn (restn),
    .d_i   (btn_in),
    .q_o   (btn_s)
  );

  assign cnt_done = (cnt_q == CNT_LAST);
  assign cnt_inc  = cnt_done ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      t_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= btn_s;
      t_out_q <= t_out_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_out_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (btn_s != prev_q) begin
          cnt_d = '0;
        end else if (cnt_done) begin
          state_d = btn_s ? ST_STABLE_HI : ST_STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_STABLE_LO: begin
        if (btn_s) begin
          state_d = ST_WAIT_HI;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!btn_s) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_done) begin
          // Only a qualified press pulses; en is looked at in this commit cycle alone.
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
          t_out_d = en;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_STABLE_HI: begin
        if (!btn_s) begin
          state_d = ST_WAIT_LO;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (btn_s) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign t_out     = t_out_q;
  assign btn_level = (state_q == ST_STABLE_HI) || (state_q == ST_WAIT_LO);
  assign busy      = (state_q == ST_INIT) || (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);

endmodule
